crop_scaler: RTL and testbench
==============================

Name: crop_scaler

Overview:
- Parametrised successor to the single-purpose pan/zoom crop stage in the camera pipeline.
- Applies a programmable crop window to an N-channel pixel stream, then integer-downscales it by 1, 2 or 4.
  - Horizontal: box average.
  - Vertical: line decimation.
- Sits between debayer and the JPEG encoder in the pixel clock domain.
- Window and scale are shadowed at frame start, so SPI writes mid-frame never tear an image.

Parameters:
- CHANNELS, 3, number of colour channels packed in the data bus
- DATA_WIDTH, 10, bits per channel
- COORD_WIDTH, 11, width of x/y counters and window coordinates

Ports:
- clock_in  input  1  pixel clock
- reset_in  input  1  synchronous, active-high reset
- data_in  input  CHANNELS*DATA_WIDTH  pixel data; channel 0 in the LSBs
- line_valid_in  input  1  line valid, also used as pixel valid
- frame_valid_in  input  1  frame valid
- x_start_in, x_end_in  input  COORD_WIDTH each  horizontal window [start, end)
- y_start_in, y_end_in  input  COORD_WIDTH each  vertical window [start, end)
- scale_in  input  2  0 = /1, 1 = /2, 2 = /4, 3 = reserved (treated as /4)
- data_out  output  CHANNELS*DATA_WIDTH  scaled pixel
- pixel_valid_out  output  1  data_out valid this cycle
- line_valid_out  output  1  output line envelope
- frame_valid_out  output  1  output frame envelope

Behaviour:
- Clock and reset: one clock (clock_in); reset (reset_in) is synchronous and active-high.
- Reset values: all outputs 0; counters 0; accumulators 0; armed = 0.
- Arming:
  - After reset, armed sets on the first cycle with frame_valid_in = 0.
  - A frame already in progress at reset release is ignored entirely.
- Shadowing: on a rising edge of frame_valid_in while armed, latch x/y start/end and scale into shadow registers. Shadows are held constant for the whole frame.
- x counter:
  - Increments on each cycle with line_valid_in = 1.
  - Clears on the falling edge of line_valid_in.
  - Saturates at all-ones.
- y counter:
  - Increments on each falling edge of line_valid_in.
  - Clears when frame_valid_in = 0.
  - Saturates at all-ones.
- Window:
  - A pixel is in-window when x_start <= x < x_end and y_start <= y < y_end.
  - Comparisons are unsigned.
  - If end <= start, nothing is emitted; frame_valid_out still toggles.
- Vertical decimation: a line is kept when (y - y_start) mod F == 0, where F = 1, 2 or 4.
- Horizontal averaging:
  - Per channel, accumulate F in-window pixels of a kept line in a DATA_WIDTH+2-bit sum.
  - On the F-th pixel, data_out = sum >> log2(F) (truncated) and pixel_valid_out pulses; accumulators clear.
  - A partial group at the window's right edge or at a line_valid_in fall is discarded; no pulse.
- Latency:
  - pixel_valid_out/data_out are registered, 1 cycle after the last pixel of the group is sampled.
  - line_valid_out = registered (kept line AND line_valid_in AND x in-window).
  - frame_valid_out = registered (frame_valid_in AND armed).
  - At F = 1, pixel_valid_out equals line_valid_out.
- Simultaneous events: a line_valid_in fall coincident with a frame_valid_in fall completes the line first; the y counter then clears.
- Reset mid-frame: outputs drop to 0 on the next clock edge; resumes at the next full frame.

Optional Feature:
- Macro: CROP_SCALER_STATS_EN.
- When defined, adds these outputs:
  - out_width_out  COORD_WIDTH: pixel_valid_out pulses in the first kept line of the last frame.
  - out_height_out  COORD_WIDTH: kept lines containing at least one pulse.
  - frame_count_out  16: count of completed frames; wraps.
- All three update on the falling edge of frame_valid_out and reset to 0.
- When undefined, these ports and their logic are absent; nothing else changes.

Test Plan:
- Window /1: 16x8 frame, window x 2..10, y 1..5, scale 0 → 4 lines of 8 pulses, one per cycle; data equals input 1 cycle later.
- Averaging /2: ramp data (channel value = x), window x 2..10, scale 1 → per line 4 pulses with values 2, 4, 6, 8 (each pair truncated); only lines y = 1 and 3 kept.
- Remainder /4: window x 2..12, y 1..9, scale 2 → 2 pulses per line (x 10, 11 dropped); kept lines y = 1 and 5 only.
- Shadowing: change x_end_in from 10 to 6 mid-frame → current frame still 8 pixels per line; next frame 4 pixels per line.
- Degenerate window: x_start = x_end = 5 → no pixel_valid_out or line_valid_out pulses; frame_valid_out mirrors the input with 1-cycle delay.
- Reset: assert reset_in at row 3 and release while frame_valid_in is high → no output until that frame ends; next frame identical to the first scenario. With CROP_SCALER_STATS_EN: width 8, height 4, frame_count 1.

Source files
------------

// File: rtl/crop_scaler.sv
// Crop window plus integer downscaler (/1, /2, /4): horizontal box average, vertical line decimation.
// Optional frame statistics outputs are built when CROP_SCALER_STATS_EN is defined.
module crop_scaler #(
  parameter int CHANNELS    = 3,
  parameter int DATA_WIDTH  = 10,
  parameter int COORD_WIDTH = 11
) (
  input  logic                           clock_in,
  input  logic                           reset_in,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                           line_valid_in,
  input  logic                           frame_valid_in,
  input  logic [COORD_WIDTH-1:0]         x_start_in,
  input  logic [COORD_WIDTH-1:0]         x_end_in,
  input  logic [COORD_WIDTH-1:0]         y_start_in,
  input  logic [COORD_WIDTH-1:0]         y_end_in,
  input  logic [1:0]                     scale_in,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic                           pixel_valid_out,
  output logic                           line_valid_out,
  output logic                           frame_valid_out
`ifdef CROP_SCALER_STATS_EN
  ,
  output logic [COORD_WIDTH-1:0]         out_width_out,
  output logic [COORD_WIDTH-1:0]         out_height_out,
  output logic [15:0]                    frame_count_out
`endif
);

  localparam int SW = DATA_WIDTH + 2;
  localparam int BW = CHANNELS * DATA_WIDTH;

  logic                   lv_d, fv_d, armed;
  logic [COORD_WIDTH-1:0] x_cnt, y_cnt;
  logic [COORD_WIDTH-1:0] xs, xe, ys, ye;
  logic [1:0]             scale, grp;
  logic [SW-1:0]          acc [CHANNELS];
  logic [SW-1:0]          sum [CHANNELS];
  logic [BW-1:0]          avg;

  logic       in_frame, line_fall, frame_rise;
  logic [1:0] fm1, y_lo;
  logic       x_in, y_keep, pix_ok, emit;

  always_comb begin
    in_frame   = frame_valid_in & armed;
    line_fall  = lv_d & ~line_valid_in;
    frame_rise = frame_valid_in & ~fv_d & armed;
    case (scale)
      2'd0:    fm1 = 2'd0;
      2'd1:    fm1 = 2'd1;
      default: fm1 = 2'd3;
    endcase
    // Only the low two bits of (y - y_start) matter for mod 1/2/4.
    y_lo   = y_cnt[1:0] - ys[1:0];
    x_in   = (x_cnt >= xs) && (x_cnt < xe);
    y_keep = (y_cnt >= ys) && (y_cnt < ye) && ((y_lo & fm1) == 2'd0);
    pix_ok = in_frame && line_valid_in && x_in && y_keep;
    emit   = pix_ok && (grp == fm1);
  end

  always_comb begin
    avg = '0;
    sum = '{default: '0};
    for (int c = 0; c < CHANNELS; c++) begin
      sum[c] = acc[c] + SW'(data_in[c*DATA_WIDTH +: DATA_WIDTH]);
      case (scale)
        2'd0:    avg[c*DATA_WIDTH +: DATA_WIDTH] = sum[c][DATA_WIDTH-1:0];
        2'd1:    avg[c*DATA_WIDTH +: DATA_WIDTH] = sum[c][DATA_WIDTH:1];
        default: avg[c*DATA_WIDTH +: DATA_WIDTH] = sum[c][DATA_WIDTH+1:2];
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      lv_d            <= 1'b0;
      fv_d            <= 1'b0;
      armed           <= 1'b0;
      x_cnt           <= '0;
      y_cnt           <= '0;
      xs              <= '0;
      xe              <= '0;
      ys              <= '0;
      ye              <= '0;
      scale           <= '0;
      grp             <= '0;
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
      data_out        <= '0;
      pixel_valid_out <= 1'b0;
      line_valid_out  <= 1'b0;
      frame_valid_out <= 1'b0;
    end else begin
      lv_d <= line_valid_in;
      fv_d <= frame_valid_in;
      if (!frame_valid_in) armed <= 1'b1;
      if (frame_rise) begin
        xs    <= x_start_in;
        xe    <= x_end_in;
        ys    <= y_start_in;
        ye    <= y_end_in;
        scale <= scale_in;
      end
      if (line_valid_in) begin
        if (x_cnt != '1) x_cnt <= x_cnt + COORD_WIDTH'(1);
      end else if (lv_d) begin
        x_cnt <= '0;
      end
      if (!frame_valid_in) y_cnt <= '0;
      else if (line_fall && (y_cnt != '1)) y_cnt <= y_cnt + COORD_WIDTH'(1);
      // Anything other than a continuing in-window pixel drops a partial group.
      if (pix_ok && !emit) begin
        grp <= grp + 2'd1;
        for (int c = 0; c < CHANNELS; c++) acc[c] <= sum[c];
      end else begin
        grp <= '0;
        for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
      end
      pixel_valid_out <= emit;
      if (emit) data_out <= avg;
      line_valid_out  <= pix_ok;
      frame_valid_out <= in_frame;
    end
  end

`ifdef CROP_SCALER_STATS_EN
  logic [COORD_WIDTH-1:0] w_run, h_run;
  logic                   first_done, line_kept, line_pulsed;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      w_run           <= '0;
      h_run           <= '0;
      first_done      <= 1'b0;
      line_kept       <= 1'b0;
      line_pulsed     <= 1'b0;
      out_width_out   <= '0;
      out_height_out  <= '0;
      frame_count_out <= '0;
    end else begin
      if (frame_rise) begin
        w_run       <= '0;
        h_run       <= '0;
        first_done  <= 1'b0;
        line_kept   <= 1'b0;
        line_pulsed <= 1'b0;
      end else begin
        if (emit && !first_done) w_run <= w_run + COORD_WIDTH'(1);
        if (line_fall) begin
          if (line_kept) first_done <= 1'b1;
          if (line_pulsed) h_run <= h_run + COORD_WIDTH'(1);
          line_kept   <= 1'b0;
          line_pulsed <= 1'b0;
        end else begin
          if (in_frame && line_valid_in && y_keep) line_kept <= 1'b1;
          if (emit) line_pulsed <= 1'b1;
        end
      end
      // Same edge as the output frame envelope falls; fold in a line ending on this cycle.
      if (frame_valid_out && !in_frame) begin
        out_width_out   <= w_run;
        out_height_out  <= h_run + COORD_WIDTH'(line_fall && line_pulsed);
        frame_count_out <= frame_count_out + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_crop_scaler.sv
// Scoreboard bench for crop_scaler: drives frames, predicts pulses/envelopes per cycle, compares at posedge+1.
module tb_crop_scaler;
  localparam int CH = 3;
  localparam int DW = 10;
  localparam int CW = 11;
  localparam int BW = CH * DW;

  logic          clk = 1'b0;
  logic          reset_in = 1'b1;
  logic [BW-1:0] data_in = '0;
  logic          line_valid_in = 1'b0;
  logic          frame_valid_in = 1'b0;
  logic [CW-1:0] x_start_in = '0, x_end_in = '0, y_start_in = '0, y_end_in = '0;
  logic [1:0]    scale_in = '0;
  logic [BW-1:0] data_out;
  logic          pixel_valid_out, line_valid_out, frame_valid_out;
`ifdef CROP_SCALER_STATS_EN
  logic [CW-1:0] out_width_out, out_height_out;
  logic [15:0]   frame_count_out;
`endif

  always #5 clk = ~clk;

  crop_scaler #(.CHANNELS(CH), .DATA_WIDTH(DW), .COORD_WIDTH(CW)) dut (
    .clock_in(clk), .reset_in(reset_in), .data_in(data_in),
    .line_valid_in(line_valid_in), .frame_valid_in(frame_valid_in),
    .x_start_in(x_start_in), .x_end_in(x_end_in),
    .y_start_in(y_start_in), .y_end_in(y_end_in), .scale_in(scale_in),
    .data_out(data_out), .pixel_valid_out(pixel_valid_out),
    .line_valid_out(line_valid_out), .frame_valid_out(frame_valid_out)
`ifdef CROP_SCALER_STATS_EN
    , .out_width_out(out_width_out), .out_height_out(out_height_out),
    .frame_count_out(frame_count_out)
`endif
  );

  int            n_checks = 0;
  int            n_errors = 0;
  logic [BW-1:0] sb_q[$];
  logic          exp_pv = 1'b0, exp_lv = 1'b0, exp_fv = 1'b0;
  bit            armed_m = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check_val("frame_valid", 64'(frame_valid_out), 64'(exp_fv));
      check_val("line_valid", 64'(line_valid_out), 64'(exp_lv));
      check_val("pixel_valid", 64'(pixel_valid_out), 64'(exp_pv));
      if (pixel_valid_out) begin
        if (sb_q.size() == 0) check_val("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        else check_val("data", 64'(data_out), 64'(sb_q.pop_front()));
      end
    end
  end

  // One input cycle; expectations describe the outputs after the next posedge.
  task automatic step(input bit rst, input bit fv, input bit lv, input logic [BW-1:0] d,
                      input bit keep, input bit last, input logic [BW-1:0] avg);
    @(negedge clk);
    reset_in       = rst;
    frame_valid_in = fv;
    line_valid_in  = lv;
    data_in        = d;
    exp_fv = !rst && fv && armed_m;
    exp_lv = !rst && fv && armed_m && lv && keep;
    exp_pv = exp_lv && last;
    if (exp_pv) sb_q.push_back(avg);
    if (rst) armed_m = 1'b0;
    else if (!fv) armed_m = 1'b1;
  endtask

  task automatic idle(input int n, input bit fv);
    repeat (n) step(1'b0, fv, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic run_frame(input int w, input int h, input int xs, input int xe,
                           input int ys, input int ye, input int sc, input bit ramp,
                           input int chg_line, input int chg_xe, input int rst_line);
    int            f, pos;
    int            sums[CH];
    bit            keep, last;
    logic [BW-1:0] d, avg;
    logic [DW-1:0] xv;
    f = (sc == 0) ? 1 : (sc == 1) ? 2 : 4;
    x_start_in = CW'(xs); x_end_in = CW'(xe);
    y_start_in = CW'(ys); y_end_in = CW'(ye);
    scale_in   = 2'(sc);
    idle(3, 1'b0);
    idle(2, 1'b1);
    for (int y = 0; y < h; y++) begin
      if (y == chg_line) x_end_in = CW'(chg_xe);
      for (int x = 0; x < w; x++) begin
        xv = x[DW-1:0];
        d  = ramp ? {xv, xv, xv} : BW'($urandom);
        keep = (x >= xs) && (x < xe) && (y >= ys) && (y < ye) && (((y - ys) % f) == 0);
        last = 1'b0;
        avg  = '0;
        if (keep) begin
          pos = (x - xs) % f;
          if (pos == 0) for (int c = 0; c < CH; c++) sums[c] = 0;
          for (int c = 0; c < CH; c++) sums[c] += int'(d[c*DW +: DW]);
          last = (pos == f - 1);
          for (int c = 0; c < CH; c++) avg[c*DW +: DW] = DW'(sums[c] / f);
        end
        step(1'b0, 1'b1, 1'b1, d, keep, last, avg);
      end
      if (y < h - 1) begin
        if (y == rst_line) repeat (2) step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        idle(3, 1'b1);
      end
    end
    // Line end and frame end on the same cycle.
    idle(1, 1'b0);
    idle(2, 1'b0);
    check_val("sb_drain", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    repeat (4) step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    idle(1, 1'b0);
    @(posedge clk); #1;
    check_val("reset_data_out", 64'(data_out), 64'd0);
    // /1 window, then /2 ramp, then /4 with right-edge remainder
    run_frame(16, 8, 2, 10, 1, 5, 0, 1'b0, -1, 0, -1);
    run_frame(16, 8, 2, 10, 1, 5, 1, 1'b1, -1, 0, -1);
    run_frame(16, 10, 2, 12, 1, 9, 2, 1'b1, -1, 0, -1);
    // shadowing: x_end changed mid-frame applies only next frame
    run_frame(16, 8, 2, 10, 1, 5, 0, 1'b0, 2, 6, -1);
    run_frame(16, 8, 2, 6, 1, 5, 0, 1'b0, -1, 0, -1);
    // degenerate window, reserved scale, odd window with random data
    run_frame(16, 8, 5, 5, 1, 5, 0, 1'b0, -1, 0, -1);
    run_frame(16, 10, 2, 12, 1, 9, 3, 1'b0, -1, 0, -1);
    run_frame(16, 9, 3, 14, 2, 9, 1, 1'b0, -1, 0, -1);
    // reset mid-frame, then a clean frame
    run_frame(16, 8, 2, 10, 1, 5, 0, 1'b0, -1, 0, 2);
    run_frame(16, 8, 2, 10, 1, 5, 0, 1'b0, -1, 0, -1);
`ifdef CROP_SCALER_STATS_EN
    check_val("stat_width", 64'(out_width_out), 64'd8);
    check_val("stat_height", 64'(out_height_out), 64'd4);
    check_val("stat_frames", 64'(frame_count_out), 64'd1);
`endif
    idle(2, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
